// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_queue
// Purpose  : Small first-word-fall-through command FIFO that sits in front of
//            the 32-bit combinational ALU. Commands (a, b, op) are accepted
//            from decode over a valid/ready handshake. The head command drives
//            the ALU operand inputs under a second valid/ready handshake.
//            Optional opcode screening drops undefined opcodes (1001-1111).
// Optional : `define ALU_ISSUE_OPCHK_EN to enable opcode screening. When it is
//            not defined, every opcode is stored and illegal_pulse and
//            illegal_cnt are tied to 0.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            in_valid/in_ready  - upstream handshake (in_ready = count < DEPTH)
//            in_a, in_b, in_op  - incoming command
//            out_valid/out_ready- downstream handshake (out_valid = count != 0)
//            out_a, out_b, out_op - head command, zero while empty
//            count              - current occupancy
//            illegal_pulse      - one-cycle pulse per dropped command
//            illegal_cnt        - saturating count of dropped commands
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [3:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic [3:0]               out_op,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     illegal_pulse,
  output logic [7:0]               illegal_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 * WIDTH + 4;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [3:0]       OP_MAX  = 4'd8;

  // Storage is intentionally not reset; count gates visibility of entries.
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic accept;
  logic op_legal;
  logic push;
  logic pop;
  logic [ENTRY_W-1:0] head;

  // Handshake signals depend only on registered occupancy, so there is no
  // combinational path from the input side to the output side.
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);

  assign accept = in_valid && in_ready;
  assign push   = accept && op_legal;
  assign pop    = out_valid && out_ready;

  assign head   = mem_q[rd_ptr_q];
  assign out_a  = out_valid ? head[ENTRY_W-1 -: WIDTH] : '0;
  assign out_b  = out_valid ? head[4 +: WIDTH]         : '0;
  assign out_op = out_valid ? head[3:0]                : 4'd0;
  assign count  = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= {in_a, in_b, in_op};
    end
  end

`ifdef ALU_ISSUE_OPCHK_EN
  logic       illegal_pulse_q;
  logic [7:0] illegal_cnt_q;
  logic       drop;

  // Illegal commands still complete the handshake but are never written.
  assign op_legal = (in_op <= OP_MAX);
  assign drop     = accept && !op_legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_pulse_q <= 1'b0;
      illegal_cnt_q   <= 8'd0;
    end else begin
      illegal_pulse_q <= drop;
      if (drop && (illegal_cnt_q != 8'hFF)) begin
        illegal_cnt_q <= illegal_cnt_q + 8'd1;
      end
    end
  end

  assign illegal_pulse = illegal_pulse_q;
  assign illegal_cnt   = illegal_cnt_q;
`else
  logic unused_op_max;
  assign unused_op_max = ^OP_MAX;
  assign op_legal      = 1'b1;
  assign illegal_pulse = 1'b0;
  assign illegal_cnt   = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_queue
// Purpose  : Self-checking bench for alu_issue_queue. A queue-based reference
//            model tracks the expected contents; directed vectors, hand-written
//            corner sequences and random traffic are compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [3:0]       out_op;
  logic [2:0]       count;
  logic             illegal_pulse;
  logic [7:0]       illegal_cnt;

  alu_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_op         (in_op),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_op        (out_op),
    .count         (count),
    .illegal_pulse (illegal_pulse),
    .illegal_cnt   (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } cmd_t;

  typedef struct {
    bit          r;
    bit          iv;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    bit          ordy;
    int          exp_count;
    bit          exp_ov;
    logic [31:0] exp_a;
    logic [3:0]  exp_op;
  } vec_t;

  cmd_t mq[$];
  bit   m_pulse;
  int   m_cnt;
  int   tests;
  int   fails;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] op);
`ifdef ALU_ISSUE_OPCHK_EN
    return (op <= 4'd8);
`else
    return 1'b1;
`endif
  endfunction

  // One clock: apply inputs, advance the model, compare every output.
  task automatic cyc(input bit r, input bit iv, input logic [31:0] a,
                     input logic [31:0] b, input logic [3:0] op, input bit ordy);
    bit   acc;
    bit   pp;
    cmd_t c;
    rst       = r;
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = ordy;
    acc = iv && (mq.size() < DEPTH);
    pp  = (mq.size() != 0) && ordy;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      m_pulse = 0;
      m_cnt   = 0;
    end else begin
      if (pp) void'(mq.pop_front());
      m_pulse = acc && !is_legal(op);
      if (acc && is_legal(op)) begin
        c.a = a; c.b = b; c.op = op;
        mq.push_back(c);
      end
      if (m_pulse && m_cnt < 255) m_cnt++;
    end
    chk("count",     32'(count),     32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
    chk("out_a",     out_a,          (mq.size() != 0) ? mq[0].a : 32'd0);
    chk("out_b",     out_b,          (mq.size() != 0) ? mq[0].b : 32'd0);
    chk("out_op",    32'(out_op),    (mq.size() != 0) ? 32'(mq[0].op) : 32'd0);
    chk("ill_pulse", 32'(illegal_pulse), 32'(m_pulse));
    chk("ill_cnt",   32'(illegal_cnt),   32'(m_cnt));
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, ordy);
  endtask

  vec_t vecs[10];
  int   pulses;
  bit   ill;

  initial begin
    tests = 0;
    fails = 0;
    m_pulse = 0;
    m_cnt = 0;
`ifdef ALU_ISSUE_OPCHK_EN
    ill = 1'b1;
`else
    ill = 1'b0;
`endif

    // Directed vectors: {rst, in_valid, a, b, op, out_ready, exp count/valid/a/op}
    vecs[0] = '{0, 1, 32'h7FFFFFFF, 32'd1, 4'd0, 0, 1, 1, 32'h7FFFFFFF, 4'd0};
    vecs[1] = '{0, 0, 32'd0,  32'd0, 4'd0, 1, 0, 0, 32'd0,  4'd0};
    vecs[2] = '{0, 1, 32'd11, 32'd0, 4'd1, 0, 1, 1, 32'd11, 4'd1};
    vecs[3] = '{0, 1, 32'd12, 32'd0, 4'd2, 0, 2, 1, 32'd11, 4'd1};
    vecs[4] = '{0, 1, 32'd13, 32'd0, 4'd3, 1, 2, 1, 32'd12, 4'd2};
    vecs[5] = '{0, 1, 32'd14, 32'd0, 4'd4, 0, 3, 1, 32'd12, 4'd2};
    vecs[6] = '{1, 1, 32'd99, 32'd0, 4'd5, 0, 0, 0, 32'd0,  4'd0};
    vecs[7] = '{0, 0, 32'd0,  32'd0, 4'd0, 1, 0, 0, 32'd0,  4'd0};
    vecs[8] = '{0, 1, 32'd5,  32'd7, 4'd8, 1, 1, 1, 32'd5,  4'd8};
    if (ill) vecs[9] = '{0, 1, 32'd6, 32'd0, 4'hF, 1, 0, 0, 32'd0, 4'd0};
    else     vecs[9] = '{0, 1, 32'd6, 32'd0, 4'hF, 1, 1, 1, 32'd6, 4'hF};

    // Reset, then idle for 10 cycles.
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++) idle(1'b0);

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].r, vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ordy);
      chk($sformatf("vec%0d_count", i), 32'(count),     32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_a", i),     out_a,          vecs[i].exp_a);
      chk($sformatf("vec%0d_op", i),    32'(out_op),    32'(vecs[i].exp_op));
    end

    // Fill to full, hold a rejected 5th push, drain in order, then wrap.
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 32'(i), 32'(i + 100), 4'(i), 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    cyc(1'b0, 1'b1, 32'd99, 32'd0, 4'd0, 1'b0);
    cyc(1'b0, 1'b1, 32'd99, 32'd0, 4'd0, 1'b0);
    chk("full_hold", 32'(count), 32'd4);
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", out_a, 32'(i));
      idle(1'b1);
    end
    chk("drained", 32'(out_valid), 32'd0);
    cyc(1'b0, 1'b1, 32'd5, 32'd0, 4'd0, 1'b1);
    for (int i = 6; i <= 10; i++) begin
      chk("wrap_order", out_a, 32'(i - 1));
      cyc(1'b0, 1'b1, 32'(i), 32'd0, 4'd0, 1'b1);
    end
    chk("wrap_last", out_a, 32'd10);
    idle(1'b1);

    // Opcode screening and saturation.
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    pulses = 0;
    cyc(1'b0, 1'b1, 32'd21, 32'd0, 4'h8, 1'b0); pulses += int'(illegal_pulse);
    cyc(1'b0, 1'b1, 32'd22, 32'd0, 4'h9, 1'b0); pulses += int'(illegal_pulse);
    cyc(1'b0, 1'b1, 32'd23, 32'd0, 4'hF, 1'b0); pulses += int'(illegal_pulse);
    cyc(1'b0, 1'b1, 32'd24, 32'd0, 4'h1, 1'b0); pulses += int'(illegal_pulse);
    idle(1'b0);                                  pulses += int'(illegal_pulse);
    chk("scr_count",  32'(count),       ill ? 32'd2 : 32'd4);
    chk("scr_pulses", 32'(pulses),      ill ? 32'd2 : 32'd0);
    chk("scr_cnt",    32'(illegal_cnt), ill ? 32'd2 : 32'd0);
    chk("scr_head0",  32'(out_op),      32'h8);
    idle(1'b1);
    chk("scr_head1",  32'(out_op),      ill ? 32'h1 : 32'h9);
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 32'(i), 32'd0, 4'hA, 1'b1);
    chk("sat_cnt", 32'(illegal_cnt), ill ? 32'd255 : 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 99) == 0), bit'($urandom_range(0, 1)), $urandom, $urandom,
          4'($urandom_range(0, 15)), bit'($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
